// File: rtl/reg_file_if.sv
// reg_file_if: decode/write-back bus between the SEQ core and the register file
//   master: drives icode/ra/rb/cnd/val_e/val_m/wb_en, receives val_a/val_b and derived IDs
//   slave : the register file side
interface reg_file_if #(parameter int DATA_W = 64);
  logic [3:0] icode, ra, rb;
  logic cnd, wb_en;
  logic [DATA_W-1:0] val_e, val_m, val_a, val_b;
  logic [3:0] src_a, src_b, dst_e, dst_m;
  modport master(output icode, ra, rb, cnd, val_e, val_m, wb_en,
                 input val_a, val_b, src_a, src_b, dst_e, dst_m);
  modport slave(input icode, ra, rb, cnd, val_e, val_m, wb_en,
                output val_a, val_b, src_a, src_b, dst_e, dst_m);
endinterface

// File: rtl/reg_file.sv
// reg_file: Y86-64 register file with decode-side ID derivation and write-back commit
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : instruction fields, write-back values/strobe, read values, derived IDs
//   dbg_sel / dbg_val : debug read port (0xF reads 0)
//   wr_count          : committed register writes since reset
module reg_file #(
  parameter int DATA_W = 64,
  parameter int NREG = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_if.slave         bus,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic [31:0]       wr_count
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP = 4'h4;
  logic [DATA_W-1:0] regs [NREG];
  logic we_e, we_m;
  assign bus.src_a = (bus.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? bus.ra :
                     (bus.icode inside {4'h9, 4'hB}) ? RSP : RNONE;
  assign bus.src_b = (bus.icode inside {4'h4, 4'h5, 4'h6}) ? bus.rb :
                     (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
  assign bus.dst_e = ((bus.icode == 4'h2 && bus.cnd) || bus.icode inside {4'h3, 4'h6}) ? bus.rb :
                     (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
  assign bus.dst_m = (bus.icode inside {4'h5, 4'hB}) ? bus.ra : RNONE;
  assign bus.val_a = (bus.src_a != RNONE) ? regs[bus.src_a] : '0;
  assign bus.val_b = (bus.src_b != RNONE) ? regs[bus.src_b] : '0;
  assign dbg_val   = (dbg_sel != RNONE) ? regs[dbg_sel] : '0;
  // when both ports target the same register, the memory result takes it as one write
  assign we_m = bus.wb_en && bus.dst_m != RNONE;
  assign we_e = bus.wb_en && bus.dst_e != RNONE && bus.dst_e != bus.dst_m;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      wr_count <= '0;
    end else begin
      if (we_e) regs[bus.dst_e] <= bus.val_e;
      if (we_m) regs[bus.dst_m] <= bus.val_m;
      wr_count <= wr_count + 32'(we_e) + 32'(we_m);
    end
  end
endmodule
